// File: rtl/riscv_rf_wb_ctrl.sv
// Write-back controller for the register file's single write port.
// Arbitrates wb0 (main pipe) against wb1 (long-latency unit), tracks
// pending long writes in a per-register scoreboard and stalls issue on
// hazards, a full outstanding count or wb1 starvation.
module riscv_rf_wb_ctrl #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic [4:0]  issue_rd,
   input  logic        issue_long,
   output logic        issue_stall,
   input  logic        wb0_valid,
   input  logic [4:0]  wb0_rd,
   input  logic [31:0] wb0_data,
   input  logic        wb1_valid,
   input  logic [4:0]  wb1_rd,
   input  logic [31:0] wb1_data,
   output logic        wb1_ready,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wd3,
   output logic        rf_we3,
   output logic [31:0] busy
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] STV_MAX = SW'(STARVE_LIMIT);

   typedef enum logic {ARB_NORMAL, ARB_STARVE} arb_t;

   arb_t          state_q, state_nxt;
   logic [SW-1:0] stv_q, stv_nxt;
   logic [CW-1:0] cnt_q;
   logic [31:0]   busy_q, busy_nxt;
   logic          wb0_gnt, wb1_gnt, denied;
   logic          hazard, full, starve_hold, accept, acc_long, cnt_dec;

   // Reset gates both grants so nothing reaches the register file.
   assign wb0_gnt   = rstn & wb0_valid;
   assign wb1_gnt   = rstn & ~wb0_valid & wb1_valid;
   assign denied    = wb0_valid & wb1_valid;
   assign wb1_ready = wb1_gnt;
   assign busy      = busy_q;

   // Fixed-priority write port mux; rd=0 is a grant without a write.
   always_comb begin
      rf_we3 = 1'b0;
      rf_a3  = '0;
      rf_wd3 = '0;
      if (wb0_gnt) begin
         rf_we3 = |wb0_rd;
         rf_a3  = wb0_rd;
         rf_wd3 = wb0_data;
      end else if (wb1_gnt) begin
         rf_we3 = |wb1_rd;
         rf_a3  = wb1_rd;
         rf_wd3 = wb1_data;
      end
   end

   // Issue hazards use registered busy only: a clearing grant is seen next cycle.
   assign hazard      = busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd];
   assign full        = issue_long & (cnt_q == CNT_MAX);
   assign issue_stall = ~rstn | (issue_valid & (hazard | full | starve_hold));
   assign accept      = issue_valid & ~issue_stall;
   assign acc_long    = accept & issue_long;
   assign cnt_dec     = wb1_gnt & (cnt_q != '0);

   // Scoreboard next value: clear on wb1 grant, set on accepted long issue.
   always_comb begin
      busy_nxt = busy_q;
      if (wb1_gnt)  busy_nxt[wb1_rd]   = 1'b0;
      if (acc_long) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard and outstanding count registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_nxt;
         case ({acc_long, cnt_dec})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Arbiter state and starve counter registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ARB_NORMAL;
         stv_q   <= '0;
      end else begin
         state_q <= state_nxt;
         stv_q   <= stv_nxt;
      end
   end

   // Next state: count denied wb1 cycles, hold issue once the limit is hit.
   always_comb begin
      state_nxt = state_q;
      stv_nxt   = stv_q;
      case (state_q)
         ARB_NORMAL: begin
            if (denied) begin
               if (stv_q >= STV_MAX - SW'(1)) begin
                  state_nxt = ARB_STARVE;
                  stv_nxt   = STV_MAX;
               end else begin
                  stv_nxt = stv_q + SW'(1);
               end
            end else begin
               stv_nxt = '0;
            end
         end
         ARB_STARVE: begin
            if (wb1_gnt) begin
               state_nxt = ARB_NORMAL;
               stv_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ARB_NORMAL;
            stv_nxt   = '0;
         end
      endcase
   end

   // FSM output: starvation holds issue until wb1 is served.
   always_comb begin
      starve_hold = 1'b0;
      if (state_q == ARB_STARVE) starve_hold = 1'b1;
   end

   // A wb1 completion with nothing outstanding means the long unit misbehaved.
   always_ff @(posedge clk) begin
      if (rstn && wb1_gnt) assert (cnt_q != '0);
   end

endmodule

// File: tb/tb_riscv_rf_wb_ctrl.sv
// Self-checking bench for riscv_rf_wb_ctrl: table of arbitration vectors
// through a scoreboard queue plus hand sequences for multi-cycle cases.
module tb_riscv_rf_wb_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issue_valid, issue_long, issue_stall;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        wb0_valid, wb1_valid, wb1_ready, rf_we3;
   logic [4:0]  wb0_rd, wb1_rd, rf_a3;
   logic [31:0] wb0_data, wb1_data, rf_wd3, busy;

   int checks = 0;
   int errors = 0;

   riscv_rf_wb_ctrl #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rstn(rstn),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_long(issue_long), .issue_stall(issue_stall),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
      .wb1_ready(wb1_ready),
      .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w0v;
      logic [4:0]  w0rd;
      logic [31:0] w0d;
      logic        w1v;
      logic [4:0]  w1rd;
      logic [31:0] w1d;
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic        e_rdy;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        rdy;
      logic        chk_wd;
   } exp_t;

   localparam int NV = 8;
   vec_t vecs [NV];
   exp_t sb [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic iss(input logic v, input logic lng, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd);
      issue_valid = v;
      issue_long  = lng;
      issue_rs1   = r1;
      issue_rs2   = r2;
      issue_rd    = rd;
   endtask

   task automatic wb0(input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb0_valid = v; wb0_rd = rd; wb0_data = d;
   endtask

   task automatic wb1(input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb1_valid = v; wb1_rd = rd; wb1_data = d;
   endtask

   initial begin
      exp_t e;
      // w0v w0rd w0d            w1v w1rd w1d            we  a3  wd             rdy
      vecs[0] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0};
      vecs[1] = '{1'b1, 5'd7,  32'h1234_5678, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h1234_5678, 1'b0};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0};
      vecs[3] = '{1'b1, 5'd3,  32'hAAAA_0001, 1'b1, 5'd4,  32'h5555_0002, 1'b1, 5'd3,  32'hAAAA_0001, 1'b0};
      vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  32'h5555_0002, 1'b1, 5'd4,  32'h5555_0002, 1'b1};
      vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 5'd0,  32'h0,         1'b1};
      vecs[6] = '{1'b1, 5'd31, 32'h8000_0001, 1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'h8000_0001, 1'b0};
      vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b1};

      // T1: reset held 3 cycles with traffic present
      rstn = 1'b0;
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd5);
      wb0(1'b1, 5'd3, 32'h0000_0001);
      wb1(1'b1, 5'd4, 32'h0000_0002);
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("rst_we3", 32'(rf_we3), 32'd0);
         chk("rst_a3", 32'(rf_a3), 32'd0);
         chk("rst_wd3", rf_wd3, 32'd0);
         chk("rst_stall", 32'(issue_stall), 32'd1);
         chk("rst_ready", 32'(wb1_ready), 32'd0);
         chk("rst_busy", busy, 32'd0);
         adv();
      end
      rstn = 1'b1;
      wb0(1'b0, 5'd0, 32'h0);
      wb1(1'b0, 5'd0, 32'h0);
      iss(1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
      smp();
      chk("post_rst_busy", busy, 32'd0);
      chk("post_rst_stall", 32'(issue_stall), 32'd0);
      adv();

      // T6: four long ops to x0 fill the outstanding count without touching busy
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("x0_long_stall", 32'(issue_stall), 32'd0);
         adv();
      end
      smp();
      chk("x0_long_busy", busy, 32'd0);
      chk("x0_full_stall", 32'(issue_stall), 32'd1);
      adv();
      iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Arbitration table through the scoreboard (includes T3 collision)
      for (int i = 0; i < NV; i++) begin
         wb0(vecs[i].w0v, vecs[i].w0rd, vecs[i].w0d);
         wb1(vecs[i].w1v, vecs[i].w1rd, vecs[i].w1d);
         sb.push_back('{vecs[i].e_we, vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_rdy,
                        vecs[i].e_we | ~(vecs[i].w0v | vecs[i].w1v)});
         smp();
         e = sb.pop_front();
         chk($sformatf("vec%0d_we3", i), 32'(rf_we3), 32'(e.we));
         chk($sformatf("vec%0d_a3", i), 32'(rf_a3), 32'(e.a3));
         if (e.chk_wd) chk($sformatf("vec%0d_wd3", i), rf_wd3, e.wd);
         chk($sformatf("vec%0d_ready", i), 32'(wb1_ready), 32'(e.rdy));
         adv();
      end
      // drain the last outstanding x0 op
      wb0(1'b0, 5'd0, 32'h0);
      wb1(1'b1, 5'd0, 32'h0);
      smp();
      chk("drain_ready", 32'(wb1_ready), 32'd1);
      adv();
      wb1(1'b0, 5'd0, 32'h0);

      // T2: RAW on x5
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd5);
      smp();
      chk("raw_issue_long", 32'(issue_stall), 32'd0);
      adv();
      iss(1'b1, 1'b0, 5'd5, 5'd0, 5'd6);
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("raw_busy", busy, 32'h0000_0020);
         chk("raw_stall", 32'(issue_stall), 32'd1);
         adv();
      end
      wb1(1'b1, 5'd5, 32'h0000_0055);
      smp();
      chk("raw_grant_stall", 32'(issue_stall), 32'd1);
      chk("raw_grant_ready", 32'(wb1_ready), 32'd1);
      chk("raw_grant_a3", 32'(rf_a3), 32'd5);
      chk("raw_grant_wd3", rf_wd3, 32'h0000_0055);
      adv();
      wb1(1'b0, 5'd0, 32'h0);
      smp();
      chk("raw_after_busy", busy, 32'd0);
      chk("raw_after_stall", 32'(issue_stall), 32'd0);
      adv();

      // T5: outstanding full
      for (int i = 1; i <= 4; i++) begin
         iss(1'b1, 1'b1, 5'd0, 5'd0, 5'(i));
         smp();
         chk("full_fill_stall", 32'(issue_stall), 32'd0);
         adv();
      end
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
      smp();
      chk("full_busy", busy, 32'h0000_001E);
      chk("full_stall", 32'(issue_stall), 32'd1);
      adv();
      iss(1'b1, 1'b0, 5'd7, 5'd8, 5'd9);
      smp();
      chk("full_alu_ok", 32'(issue_stall), 32'd0);
      adv();
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
      wb1(1'b1, 5'd1, 32'h0000_0101);
      smp();
      chk("full_same_cycle_stall", 32'(issue_stall), 32'd1);
      chk("full_grant_ready", 32'(wb1_ready), 32'd1);
      adv();
      wb1(1'b0, 5'd0, 32'h0);
      smp();
      chk("full_freed_stall", 32'(issue_stall), 32'd0);
      adv();
      iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      smp();
      chk("full_busy_after", busy, 32'h0000_005C);
      adv();
      for (int i = 0; i < 4; i++) begin
         logic [4:0] rds [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
         wb1(1'b1, rds[i], 32'(i));
         smp();
         chk("full_drain_ready", 32'(wb1_ready), 32'd1);
         adv();
      end
      wb1(1'b0, 5'd0, 32'h0);
      smp();
      chk("full_drain_busy", busy, 32'd0);
      adv();

      // T4: starvation of wb1 by continuous wb0
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd10);
      smp();
      chk("stv_issue_long", 32'(issue_stall), 32'd0);
      adv();
      iss(1'b1, 1'b0, 5'd12, 5'd12, 5'd13);
      wb0(1'b1, 5'd11, 32'h1111_0011);
      wb1(1'b1, 5'd10, 32'h0BAD_0010);
      for (int k = 1; k <= 8; k++) begin
         smp();
         chk($sformatf("stv_pre%0d_stall", k), 32'(issue_stall), 32'd0);
         chk("stv_pre_ready", 32'(wb1_ready), 32'd0);
         adv();
      end
      for (int k = 0; k < 2; k++) begin
         smp();
         chk("stv_hold_stall", 32'(issue_stall), 32'd1);
         chk("stv_hold_a3", 32'(rf_a3), 32'd11);
         adv();
      end
      wb0(1'b0, 5'd0, 32'h0);
      smp();
      chk("stv_grant_ready", 32'(wb1_ready), 32'd1);
      chk("stv_grant_a3", 32'(rf_a3), 32'd10);
      chk("stv_grant_stall", 32'(issue_stall), 32'd1);
      adv();
      wb1(1'b0, 5'd0, 32'h0);
      smp();
      chk("stv_normal_stall", 32'(issue_stall), 32'd0);
      chk("stv_busy", busy, 32'd0);
      adv();

      // Reset mid-operation discards scoreboard and pending wb1
      iss(1'b1, 1'b1, 5'd0, 5'd0, 5'd20);
      adv();
      iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      wb0(1'b1, 5'd1, 32'h1);
      wb1(1'b1, 5'd20, 32'h20);
      smp();
      chk("midrst_busy_before", busy, 32'h0010_0000);
      adv();
      rstn = 1'b0;
      smp();
      chk("midrst_ready", 32'(wb1_ready), 32'd0);
      adv();
      rstn = 1'b1;
      wb0(1'b0, 5'd0, 32'h0);
      wb1(1'b0, 5'd0, 32'h0);
      smp();
      chk("midrst_busy_after", busy, 32'd0);
      adv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
